// File: rtl/dtc_code_ctrl.sv
// dtc_code_ctrl
//   Clocked code generator that drives the DTC delay line. Each reference cycle
//   it turns a fractional phase target into a saturated DTC control word.
//   A two-stage valid-tagged pipeline scales FRAC by GAIN, then adds a
//   per-segment INL correction taken from a writable LUT.
//   A sign-LMS loop trims GAIN from the bang-bang phase detector sign.
//
// Ports
//   clk        in   reference-rate clock, all logic on posedge
//   nrst       in   asynchronous active-low reset
//   en         in   block enable; low flushes in-flight samples
//   frac       in   fractional phase target (unsigned)
//   frac_vld   in   frac valid strobe
//   pe_sgn     in   BBPD sign: 1 = DTC delay too short, 0 = too long
//   pe_vld     in   pe_sgn valid strobe (refers to last emitted dtcdcw)
//   cal_en     in   enable LMS gain update
//   gain_load  in   load gain_init into the gain register (wins over LMS)
//   gain_init  in   gain preset value
//   lut_we     in   INL LUT write enable (independent of en)
//   lut_waddr  in   INL LUT write address
//   lut_wdata  in   INL LUT write data, two's complement DTC LSBs
//   dtcdcw     out  registered DTC control word
//   dcw_vld    out  one-cycle pulse when dtcdcw is updated
//   sat        out  dtcdcw was clipped, held until next update
//   gain       out  current gain register
module dtc_code_ctrl #(
  parameter int FRAC_W = 16,
  parameter int GAIN_W = 16,
  parameter int DTC_W  = 12,
  parameter int LUT_AW = 5,
  parameter int LUT_DW = 8,
  parameter int MU_SH  = 10,
  parameter logic [GAIN_W-1:0] GAIN_RST = 16'h8000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic [FRAC_W-1:0] frac,
  input  logic              frac_vld,
  input  logic              pe_sgn,
  input  logic              pe_vld,
  input  logic              cal_en,
  input  logic              gain_load,
  input  logic [GAIN_W-1:0] gain_init,
  input  logic              lut_we,
  input  logic [LUT_AW-1:0] lut_waddr,
  input  logic [LUT_DW-1:0] lut_wdata,
  output logic [DTC_W-1:0]  dtcdcw,
  output logic              dcw_vld,
  output logic              sat,
  output logic [GAIN_W-1:0] gain
);

  localparam int PROD_W = FRAC_W + GAIN_W;
  localparam int SUM_W  = DTC_W + 2;

  logic [LUT_DW-1:0] lut [2**LUT_AW];

  logic              s1_vld;
  logic [DTC_W-1:0]  s1_code;
  logic [LUT_AW-1:0] s1_idx;
  logic [FRAC_W-1:0] s1_frac;
  logic [FRAC_W-1:0] frac_applied;

  logic [PROD_W-1:0] prod;
  logic [DTC_W-1:0]  code_lin;
  logic [LUT_DW-1:0] lut_rd;
  logic [SUM_W-1:0]  sum;
  logic [DTC_W-1:0]  code_clip;
  logic              clip;
  logic [GAIN_W:0]   step_ext;
  logic [GAIN_W:0]   gain_up;
  logic [GAIN_W:0]   gain_dn;
  logic [GAIN_W-1:0] gain_lms;

  // Stage-1 arithmetic: keep the top DTC_W bits of the full product, i.e.
  // plain truncation. Uses the gain register as it stands before this edge.
  always_comb begin
    prod     = PROD_W'(frac) * PROD_W'(gain);
    code_lin = prod[PROD_W-1 -: DTC_W];
  end

  // Stage-2 arithmetic: add the sign-extended INL entry at two extra bits of
  // headroom, then clip. The sum is never below -2^(LUT_DW-1) nor above
  // 2^DTC_W + 2^(LUT_DW-1), so the top bit is the sign and bit DTC_W flags
  // overflow. The LUT read sees the pre-write entry on a same-edge write.
  always_comb begin
    lut_rd    = lut[s1_idx];
    sum       = {2'b00, s1_code} + {{(SUM_W-LUT_DW){lut_rd[LUT_DW-1]}}, lut_rd};
    code_clip = sum[DTC_W-1:0];
    clip      = 1'b0;
    if (sum[SUM_W-1]) begin
      code_clip = '0;
      clip      = 1'b1;
    end else if (sum[DTC_W]) begin
      code_clip = '1;
      clip      = 1'b1;
    end
  end

  // LMS step candidate: +/- (frac_applied >> MU_SH), saturating at both ends
  // instead of wrapping. The extra MSB of each path is the carry/borrow.
  always_comb begin
    step_ext = (GAIN_W+1)'(frac_applied >> MU_SH);
    gain_up  = {1'b0, gain} + step_ext;
    gain_dn  = {1'b0, gain} - step_ext;
    if (pe_sgn) begin
      gain_lms = gain_up[GAIN_W] ? '1 : gain_up[GAIN_W-1:0];
    end else begin
      gain_lms = gain_dn[GAIN_W] ? '0 : gain_dn[GAIN_W-1:0];
    end
  end

  // Pipeline registers. Dropping en clears both valid tags so nothing
  // in flight emerges later; data registers simply hold.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_vld       <= 1'b0;
      s1_code      <= '0;
      s1_idx       <= '0;
      s1_frac      <= '0;
      dtcdcw       <= '0;
      dcw_vld      <= 1'b0;
      sat          <= 1'b0;
      frac_applied <= '0;
    end else begin
      s1_vld  <= en & frac_vld;
      dcw_vld <= en & s1_vld;
      if (en && frac_vld) begin
        s1_code <= code_lin;
        s1_idx  <= code_lin[DTC_W-1 -: LUT_AW];
        s1_frac <= frac;
      end
      if (en && s1_vld) begin
        dtcdcw       <= code_clip;
        sat          <= clip;
        frac_applied <= s1_frac;
      end
    end
  end

  // Gain register: an explicit preload beats the LMS update and works
  // even while the block is disabled.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      gain <= GAIN_RST;
    end else if (gain_load) begin
      gain <= gain_init;
    end else if (en && cal_en && pe_vld) begin
      gain <= gain_lms;
    end
  end

  // INL LUT: written regardless of en, cleared to zero correction on reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 2**LUT_AW; i++) begin
        lut[i] <= '0;
      end
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

endmodule

// File: tb/tb_dtc_code_ctrl.sv
// tb_dtc_code_ctrl
//   Directed bench for dtc_code_ctrl. Expected codes are pushed into a queue
//   together with the cycle they must appear in; a negedge monitor pops and
//   compares whenever dcw_vld is seen. Gain and reset values are checked
//   directly from the stimulus thread.
module tb_dtc_code_ctrl;

  logic        clk;
  logic        nrst;
  logic        en;
  logic [15:0] frac;
  logic        frac_vld;
  logic        pe_sgn;
  logic        pe_vld;
  logic        cal_en;
  logic        gain_load;
  logic [15:0] gain_init;
  logic        lut_we;
  logic [4:0]  lut_waddr;
  logic [7:0]  lut_wdata;
  logic [11:0] dtcdcw;
  logic        dcw_vld;
  logic        sat;
  logic [15:0] gain;

  typedef struct {
    logic [11:0] code;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;

  dtc_code_ctrl dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .frac      (frac),
    .frac_vld  (frac_vld),
    .pe_sgn    (pe_sgn),
    .pe_vld    (pe_vld),
    .cal_en    (cal_en),
    .gain_load (gain_load),
    .gain_init (gain_init),
    .lut_we    (lut_we),
    .lut_waddr (lut_waddr),
    .lut_wdata (lut_wdata),
    .dtcdcw    (dtcdcw),
    .dcw_vld   (dcw_vld),
    .sat       (sat),
    .gain      (gain)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running edge counter used to time-stamp expected outputs.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one FRAC sample for a cycle; its code must show up with dcw_vld
  // after the second edge following the drive point.
  task automatic apply_stimulus(input logic [15:0] f, input logic [11:0] code, input logic s);
    exp_t e;
    e.code = code;
    e.sat  = s;
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
    frac     = f;
    frac_vld = 1'b1;
    tick();
    frac_vld = 1'b0;
  endtask

  task automatic write_lut(input logic [4:0] a, input logic [7:0] d);
    lut_we    = 1'b1;
    lut_waddr = a;
    lut_wdata = d;
    tick();
    lut_we    = 1'b0;
  endtask

  task automatic load_gain(input logic [15:0] g);
    gain_load = 1'b1;
    gain_init = g;
    tick();
    gain_load = 1'b0;
  endtask

  task automatic pe_pulse(input logic s);
    pe_sgn = s;
    pe_vld = 1'b1;
    tick();
    pe_vld = 1'b0;
  endtask

  // Monitor: every dcw_vld pulse must match the oldest expected entry, both
  // in value and in the cycle it appears.
  always @(negedge clk) begin
    if (nrst && dcw_vld) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_dcw_vld actual=%0h expected=none", dtcdcw);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_output("dtcdcw", int'(dtcdcw), int'(e.code));
        check_output("sat", int'(sat), int'(e.sat));
        check_output("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    nrst      = 1'b0;
    en        = 1'b0;
    frac      = '0;
    frac_vld  = 1'b0;
    pe_sgn    = 1'b0;
    pe_vld    = 1'b0;
    cal_en    = 1'b0;
    gain_load = 1'b0;
    gain_init = '0;
    lut_we    = 1'b0;
    lut_waddr = '0;
    lut_wdata = '0;
    repeat (3) tick();

    check_output("rst_dtcdcw", int'(dtcdcw), 0);
    check_output("rst_dcw_vld", int'(dcw_vld), 0);
    check_output("rst_sat", int'(sat), 0);
    check_output("rst_gain", int'(gain), 'h8000);

    nrst = 1'b1;
    en   = 1'b1;
    tick();

    // Linear path, full gain, back-to-back samples.
    load_gain(16'hFFFF);
    check_output("gain_load_ffff", int'(gain), 'hFFFF);
    apply_stimulus(16'h8000, 12'd2047, 1'b0);
    apply_stimulus(16'h8000, 12'd2047, 1'b0);
    apply_stimulus(16'h4000, 12'd1023, 1'b0);
    repeat (3) tick();

    // INL correction and clipping at both ends.
    write_lut(5'd15, 8'hFD);
    apply_stimulus(16'h8000, 12'd2044, 1'b0);
    write_lut(5'd31, 8'h7F);
    apply_stimulus(16'hFFFF, 12'd4095, 1'b1);
    write_lut(5'd0, 8'hFB);
    apply_stimulus(16'h0000, 12'd0, 1'b1);
    repeat (3) tick();

    // LMS: code 512 from FRAC 0x4000 at gain 0x8000, step = 0x4000>>10 = 16.
    load_gain(16'h8000);
    apply_stimulus(16'h4000, 12'd512, 1'b0);
    tick();
    cal_en = 1'b1;
    pe_pulse(1'b1);
    check_output("lms_up", int'(gain), 'h8010);
    pe_pulse(1'b0);
    pe_pulse(1'b0);
    check_output("lms_down2", int'(gain), 'h7FF0);
    load_gain(16'hFFF8);
    check_output("gain_load_fff8", int'(gain), 'hFFF8);
    pe_pulse(1'b1);
    check_output("lms_sat_high", int'(gain), 'hFFFF);

    // Priority: preload beats LMS; cal_en low freezes gain.
    gain_load = 1'b1;
    gain_init = 16'h1234;
    pe_sgn    = 1'b1;
    pe_vld    = 1'b1;
    tick();
    gain_load = 1'b0;
    pe_vld    = 1'b0;
    check_output("load_over_lms", int'(gain), 'h1234);
    cal_en = 1'b0;
    pe_pulse(1'b1);
    check_output("cal_off_hold", int'(gain), 'h1234);

    // Enable drop with samples in flight: nothing emerges, output holds.
    load_gain(16'hFFFF);
    frac     = 16'h8000;
    frac_vld = 1'b1;
    tick();
    frac     = 16'h4000;
    en       = 1'b0;
    tick();
    frac_vld = 1'b0;
    repeat (3) tick();
    check_output("en_drop_hold", int'(dtcdcw), 512);
    en = 1'b1;
    apply_stimulus(16'h8000, 12'd2044, 1'b0);
    repeat (4) tick();

    // Async reset mid-stream, asserted between edges.
    apply_stimulus(16'hFFFF, 12'd4095, 1'b1);
    #2;
    nrst = 1'b0;
    exp_q.delete();
    #1;
    check_output("midrst_dtcdcw", int'(dtcdcw), 0);
    check_output("midrst_dcw_vld", int'(dcw_vld), 0);
    check_output("midrst_gain", int'(gain), 'h8000);
    repeat (2) tick();
    nrst = 1'b1;
    repeat (3) tick();

    check_output("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
